// File: rtl/av2_obu_packer_if.sv
// Descriptor, payload and output stream bundle for the OBU packer.
// master = packer side, slave = producer/sink environment side.
interface av2_obu_packer_if #(
    parameter int unsigned DATA_WIDTH = 128
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    logic [3:0]            obu_type;
    logic [31:0]           obu_size;
    logic                  obu_valid;
    logic                  obu_ready;

    logic [DATA_WIDTH-1:0] s_pay_tdata;
    logic                  s_pay_tvalid;
    logic                  s_pay_tready;
    logic                  s_pay_tlast;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  obu_type, obu_size, obu_valid,
        output obu_ready,
        input  s_pay_tdata, s_pay_tvalid, s_pay_tlast,
        output s_pay_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        output obu_type, obu_size, obu_valid,
        input  obu_ready,
        output s_pay_tdata, s_pay_tvalid, s_pay_tlast,
        input  s_pay_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/av2_obu_packer.sv
// OBU packer: emits one header beat (type/size) followed by the payload
// beats of each descriptor on a single-slot registered AXI4-Stream output.
module av2_obu_packer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    av2_obu_packer_if.master     bus,
    output logic                 err_len,
    output logic [CNT_WIDTH-1:0] obu_count,
    output logic                 busy
);
    localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
    localparam int unsigned BEATS_W = 29;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            type_q, type_d;
    logic [31:0]           size_q, size_d;
    logic [BEATS_W-1:0]    rem_q, rem_d;
    logic [KEEP_W-1:0]     lastkeep_q, lastkeep_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic                  slot_free_c;
    logic                  pay_ready_c;
    logic                  rem_one_c;
    logic [BEATS_W-1:0]    beats_c;
    logic [KEEP_W-1:0]     lastkeep_c;

    assign slot_free_c = !tvalid_q || bus.m_axis_tready;
    assign rem_one_c   = (rem_q == BEATS_W'(1));
    // 33-bit round-up so a size of 0xFFFFFFFF yields 0x10000000 beats
    assign beats_c     = BEATS_W'(({1'b0, bus.obu_size} + 33'd15) >> 4);
    assign lastkeep_c  = (bus.obu_size[3:0] == 4'd0) ? {KEEP_W{1'b1}}
                       : KEEP_W'((32'd1 << bus.obu_size[3:0]) - 32'd1);

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        size_d      = size_q;
        rem_d       = rem_q;
        lastkeep_d  = lastkeep_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        pay_ready_c = 1'b0;

        if (tvalid_q && bus.m_axis_tready) begin
            tvalid_d = 1'b0;
            if (tlast_q) cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.obu_valid) begin
                    type_d     = bus.obu_type;
                    size_d     = bus.obu_size;
                    rem_d      = beats_c;
                    lastkeep_d = lastkeep_c;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (slot_free_c) begin
                    tdata_d  = DATA_WIDTH'({size_q, 88'd0, type_q, 4'd0});
                    tkeep_d  = {KEEP_W{1'b1}};
                    tlast_d  = (rem_q == '0);
                    tvalid_d = 1'b1;
                    state_d  = (rem_q == '0) ? ST_IDLE : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                pay_ready_c = slot_free_c;
                if (bus.s_pay_tvalid && slot_free_c) begin
                    tdata_d  = bus.s_pay_tdata;
                    tlast_d  = rem_one_c;
                    tkeep_d  = rem_one_c ? lastkeep_q : {KEEP_W{1'b1}};
                    tvalid_d = 1'b1;
                    rem_d    = rem_q - BEATS_W'(1);
                    // framing follows the local count; upstream tlast only flags errors
                    if (bus.s_pay_tlast != rem_one_c) err_d = 1'b1;
                    if (rem_one_c) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE) || tvalid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            type_q     <= '0;
            size_q     <= '0;
            rem_q      <= '0;
            lastkeep_q <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            size_q     <= size_d;
            rem_q      <= rem_d;
            lastkeep_q <= lastkeep_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.obu_ready     = ready_q;
    assign bus.s_pay_tready  = pay_ready_c;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tkeep  = tkeep_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign err_len           = err_q;
    assign obu_count         = cnt_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_av2_obu_packer.sv
// Directed bench for av2_obu_packer: drives descriptors and payload,
// collects output beats and compares them against hand-computed values.
module tb_av2_obu_packer;
    logic        clk;
    logic        rst_n;
    logic        err_len;
    logic [15:0] obu_count;
    logic        busy;

    av2_obu_packer_if #(.DATA_WIDTH(128)) bus ();

    av2_obu_packer #(.DATA_WIDTH(128), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_len   (err_len),
        .obu_count (obu_count),
        .busy      (busy)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t        beats[$];
    int           checks   = 0;
    int           failures = 0;
    logic         stall_en = 1'b0;
    logic         hold_pend = 1'b0;
    beat_t        prev_beat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [3:0] t, input logic [31:0] s);
        return {s, 88'd0, t, 4'd0};
    endfunction

    function automatic logic [127:0] pat(input logic [7:0] k);
        return {4{24'hC0FFEE, k}};
    endfunction

    // Output monitor: records handshakes and checks stability across stalls
    always @(negedge clk) begin
        if (hold_pend && rst_n) begin
            check("hold_data", bus.m_axis_tdata, prev_beat.d);
            check("hold_keep", 128'(bus.m_axis_tkeep), 128'(prev_beat.k));
            check("hold_last", 128'(bus.m_axis_tlast), 128'(prev_beat.l));
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready)
            beats.push_back('{d: bus.m_axis_tdata, k: bus.m_axis_tkeep, l: bus.m_axis_tlast});
        hold_pend = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_beat = '{d: bus.m_axis_tdata, k: bus.m_axis_tkeep, l: bus.m_axis_tlast};
    end

    always begin
        @(posedge clk);
        #1;
        if (stall_en) bus.m_axis_tready = 1'($urandom_range(0, 1));
    end

    task automatic send_desc(input logic [3:0] t, input logic [31:0] s);
        int n;
        bus.obu_type  = t;
        bus.obu_size  = s;
        bus.obu_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.obu_ready) break;
        end
        if (n == 200) check("desc_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        bus.obu_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [127:0] d, input logic l);
        int n;
        bus.s_pay_tdata  = d;
        bus.s_pay_tlast  = l;
        bus.s_pay_tvalid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.s_pay_tready) break;
        end
        if (n == 200) check("pay_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        bus.s_pay_tvalid = 1'b0;
        bus.s_pay_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int c;
        for (c = 0; c < 300; c++) begin
            if (beats.size() >= n) break;
            @(negedge clk);
        end
        if (beats.size() < n) check("drain_timeout", 128'(beats.size()), 128'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input string tag, input int i, input logic [127:0] d,
                            input logic [15:0] k, input logic l);
        if (i < beats.size()) begin
            check({tag, "_data"}, beats[i].d, d);
            check({tag, "_keep"}, 128'(beats[i].k), 128'(k));
            check({tag, "_last"}, 128'(beats[i].l), 128'(l));
        end else begin
            check({tag, "_missing"}, 128'(beats.size()), 128'(i + 1));
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.obu_type      = '0;
        bus.obu_size      = '0;
        bus.obu_valid     = 1'b0;
        bus.s_pay_tdata   = '0;
        bus.s_pay_tvalid  = 1'b0;
        bus.s_pay_tlast   = 1'b0;
        bus.m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 128'(bus.m_axis_tvalid), 128'd0);
        check("rst_tdata", bus.m_axis_tdata, 128'd0);
        check("rst_tkeep", 128'(bus.m_axis_tkeep), 128'd0);
        check("rst_tlast", 128'(bus.m_axis_tlast), 128'd0);
        check("rst_obu_ready", 128'(bus.obu_ready), 128'd1);
        check("rst_pay_ready", 128'(bus.s_pay_tready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_count", 128'(obu_count), 128'd0);
        check("rst_err", 128'(err_len), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: empty OBU, header only; header appears two cycles after acceptance
        beats.delete();
        send_desc(4'd1, 32'd0);
        @(negedge clk);
        check("t1_lat_n1", 128'(bus.m_axis_tvalid), 128'd0);
        @(negedge clk);
        check("t1_lat_n2", 128'(bus.m_axis_tvalid), 128'd1);
        wait_beats(1);
        exp_beat("t1_hdr", 0, hdr(4'd1, 32'd0), 16'hFFFF, 1'b1);
        check("t1_nbeats", 128'(beats.size()), 128'd1);
        check("t1_count", 128'(obu_count), 128'd1);
        check("t1_err", 128'(err_len), 128'd0);

        // 2: 20-byte payload, partial last beat
        beats.delete();
        send_desc(4'd6, 32'd20);
        send_pay(pat(8'h21), 1'b0);
        send_pay(pat(8'h22), 1'b1);
        wait_beats(3);
        exp_beat("t2_hdr", 0, hdr(4'd6, 32'd20), 16'hFFFF, 1'b0);
        exp_beat("t2_p0", 1, pat(8'h21), 16'hFFFF, 1'b0);
        exp_beat("t2_p1", 2, pat(8'h22), 16'h000F, 1'b1);
        check("t2_count", 128'(obu_count), 128'd2);
        check("t2_err", 128'(err_len), 128'd0);

        // 3: 32 bytes with random output backpressure
        beats.delete();
        stall_en = 1'b1;
        send_desc(4'd3, 32'd32);
        send_pay(pat(8'h31), 1'b0);
        send_pay(pat(8'h32), 1'b1);
        wait_beats(3);
        stall_en = 1'b0;
        @(posedge clk);
        #2;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t3_nbeats", 128'(beats.size()), 128'd3);
        exp_beat("t3_hdr", 0, hdr(4'd3, 32'd32), 16'hFFFF, 1'b0);
        exp_beat("t3_p0", 1, pat(8'h31), 16'hFFFF, 1'b0);
        exp_beat("t3_p1", 2, pat(8'h32), 16'hFFFF, 1'b1);
        check("t3_count", 128'(obu_count), 128'd3);

        // 4: upstream tlast arrives one beat early
        beats.delete();
        send_desc(4'd4, 32'd48);
        send_pay(pat(8'h41), 1'b0);
        check("t4_err_pre", 128'(err_len), 128'd0);
        send_pay(pat(8'h42), 1'b1);
        check("t4_err_set", 128'(err_len), 128'd1);
        send_pay(pat(8'h43), 1'b0);
        wait_beats(4);
        exp_beat("t4_hdr", 0, hdr(4'd4, 32'd48), 16'hFFFF, 1'b0);
        exp_beat("t4_p0", 1, pat(8'h41), 16'hFFFF, 1'b0);
        exp_beat("t4_p1", 2, pat(8'h42), 16'hFFFF, 1'b0);
        exp_beat("t4_p2", 3, pat(8'h43), 16'hFFFF, 1'b1);
        check("t4_count", 128'(obu_count), 128'd4);
        check("t4_err_sticky", 128'(err_len), 128'd1);

        // 5: second descriptor accepted while first final beat is still pending
        beats.delete();
        send_desc(4'd2, 32'd16);
        send_pay(pat(8'h51), 1'b1);
        bus.m_axis_tready = 1'b0;
        bus.obu_type  = 4'd3;
        bus.obu_size  = 32'd5;
        bus.obu_valid = 1'b1;
        @(negedge clk);
        check("t5_rdy_while_pend", 128'(bus.obu_ready), 128'd1);
        check("t5_pend_valid", 128'(bus.m_axis_tvalid), 128'd1);
        check("t5_pend_last", 128'(bus.m_axis_tlast), 128'd1);
        @(posedge clk);
        #1;
        bus.obu_valid = 1'b0;
        bus.m_axis_tready = 1'b1;
        send_pay(pat(8'h52), 1'b1);
        wait_beats(4);
        check("t5_nbeats", 128'(beats.size()), 128'd4);
        exp_beat("t5_hdr0", 0, hdr(4'd2, 32'd16), 16'hFFFF, 1'b0);
        exp_beat("t5_p0", 1, pat(8'h51), 16'hFFFF, 1'b1);
        exp_beat("t5_hdr1", 2, hdr(4'd3, 32'd5), 16'hFFFF, 1'b0);
        exp_beat("t5_p1", 3, pat(8'h52), 16'h001F, 1'b1);
        if (beats.size() >= 4) begin
            check("t5_parse_type0", 128'(beats[0].d[7:4]), 128'd2);
            check("t5_parse_size0", 128'(beats[0].d[127:96]), 128'd16);
            check("t5_parse_type1", 128'(beats[2].d[7:4]), 128'd3);
            check("t5_parse_size1", 128'(beats[2].d[127:96]), 128'd5);
        end
        check("t5_count", 128'(obu_count), 128'd6);

        // 6: reset in the middle of a 64-byte payload, then a fresh empty OBU
        send_desc(4'd5, 32'd64);
        send_pay(pat(8'h61), 1'b0);
        send_pay(pat(8'h62), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_tvalid", 128'(bus.m_axis_tvalid), 128'd0);
        check("t6_obu_ready", 128'(bus.obu_ready), 128'd1);
        check("t6_busy", 128'(busy), 128'd0);
        check("t6_count", 128'(obu_count), 128'd0);
        check("t6_err", 128'(err_len), 128'd0);
        check("t6_pay_ready", 128'(bus.s_pay_tready), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beats.delete();
        send_desc(4'd9, 32'd0);
        wait_beats(1);
        check("t6_nbeats", 128'(beats.size()), 128'd1);
        exp_beat("t6_hdr", 0, hdr(4'd9, 32'd0), 16'hFFFF, 1'b1);
        check("t6_count_after", 128'(obu_count), 128'd1);
        check("t6_busy_after", 128'(busy), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
